merging_store_buffer: RTL and testbench
=======================================

MERGING_STORE_BUFFER -- requirements
Module: merging_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two and at least 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, entry data width; a multiple of 8. BE = DATA_WIDTH/8 and OFS = log2(BE).
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard all entries.
- push_valid_i  in  1  store request.
- push_ready_o  out  1  store accepted when high together with push_valid_i.
- push_address_i  in  ADDR_WIDTH  store byte address.
- push_data_i  in  DATA_WIDTH  store data.
- push_byte_en_i  in  BE  store byte enables.
- pop_valid_o  out  1  head entry present.
- pop_ready_i  in  1  memory controller takes head.
- pop_address_o  out  ADDR_WIDTH  head address, low OFS bits zero.
- pop_data_o  out  DATA_WIDTH  head data.
- pop_byte_en_o  out  BE  head byte enables.
- fwd_address_i  in  ADDR_WIDTH  load lookup address.
- fwd_hit_o  out  1  lookup matched a valid entry.
- fwd_data_o  out  DATA_WIDTH  matched entry data.
- fwd_byte_en_o  out  BE  matched entry byte enables.
- full_o  out  1  count equals DEPTH.
- empty_o  out  1  count equals 0.
- count_o  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-005 SHALL operate as a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus a separate occupancy counter, so full and empty are never ambiguous.
REQ-006 SHALL compare addresses on word granularity, ignoring address bits [OFS-1:0].
REQ-007 SHALL treat a push as a merge when push_address_i matches a valid entry that is not being popped in the same cycle:
- for each byte with push_byte_en_i set, the entry's byte is overwritten;
- the entry's byte enables become the OR of old and new;
- pointers and count are unchanged.
REQ-008 SHALL otherwise allocate an accepted push at the tail: store data and enables, advance tail, increment count.
REQ-009 SHALL drive push_ready_o as a combinational signal: high if a merge hit exists or full_o is low; low during flush_i.
REQ-010 SHALL present the head entry first-word-fall-through: pop_valid_o = !empty_o, and outputs are valid in the same cycle.
REQ-011 SHALL treat pop_valid_o and pop_ready_i both high as a pop: head is invalidated, head pointer advances, count decrements.
REQ-012 SHALL handle a push matching the head while the head is popped in the same cycle as a new allocation, never as a merge.
REQ-013 SHALL apply simultaneous allocate and pop with count unchanged; a merge plus a pop decrements count.
REQ-014 SHALL NOT accept a push to a full buffer without a merge hit, even if a pop occurs in that cycle.
REQ-015 SHALL guarantee that at most one valid entry holds any given word address.
REQ-016 SHALL compute forwarding combinationally from registered state only; a same-cycle push is not visible.
- fwd_hit_o and fwd_byte_en_o are zero on a miss.
- fwd_data_o is don't-care on a miss.
REQ-017 SHALL, on flush_i, clear all valid bits, both pointers and the count on the next edge; flush overrides same-cycle push and pop, and neither is performed.
REQ-018 SHALL register full_o, empty_o and count_o, updated on the same edge as the state they describe.
REQ-019 SHALL drive the pop outputs with head-entry contents whenever pop_valid_o is low or high; consumers ignore them while pop_valid_o is low.

Reset
REQ-020 SHALL, on rst_i high at a rising edge, set all valid bits 0, pointers 0, count_o 0, empty_o 1, full_o 0; as a result pop_valid_o is 0 and fwd_hit_o is 0.
REQ-021 SHALL give rst_i priority over flush_i, push and pop; entry data and address storage need no reset.

Structure
REQ-022 SHALL take default constants (ST_BUF_DEPTH, address width, data width) from data_memory_pkg; the entry record (address, data, byte_en) is declared in the module because it depends on the parameters.
REQ-023 SHALL place the per-entry word-address comparison in one sub-module, store_buffer_match (DEPTH comparators producing a one-hot hit vector and its encoded index), instantiated twice: once for push and once for forwarding.

Verification
REQ-024 Reset then push 0x100 / 0xAABBCCDD / byte_en 4'hF -> next cycle count_o=1, pop_valid_o=1, pop_data_o=0xAABBCCDD.
REQ-025 Push 0x200 / 0x11223344 / byte_en 4'h3, then push 0x202 / 0x5566xxxx / byte_en 4'hC -> count_o=1, data 0x55663344, byte_en 4'hF.
REQ-026 Fill DEPTH=4 with addresses 0x0, 0x4, 0x8, 0xC -> full_o=1; push 0x10 gives push_ready_o=0; push 0x8 gives push_ready_o=1 (merge).
REQ-027 With count_o=2, push new address and pop in the same cycle -> count_o stays 2; pointers wrap after 5 further push/pop pairs with FIFO order preserved.
REQ-028 Entry 0x300 holds 0xDEADBEEF; fwd_address_i=0x301 -> fwd_hit_o=1, fwd_data_o=0xDEADBEEF; fwd_address_i=0x304 -> fwd_hit_o=0.
REQ-029 With 3 entries, assert flush_i with push_valid_i and pop_ready_i high -> next cycle count_o=0, empty_o=1, push not stored.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared constants for the data-memory subsystem.
// Supplies the default store-buffer depth and the address/data widths
// used by merging_store_buffer and its helpers.
package data_memory_pkg;

  localparam int ST_BUF_DEPTH   = 4;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

endpackage : data_memory_pkg

// File: rtl/merging_store_buffer_match.sv
// store_buffer_match: word-granular address comparator bank.
// Compares one lookup address against every entry of the store buffer and
// returns a one-hot hit vector plus the encoded index of the hit.
// Ports:
//   addr        lookup byte address
//   entry_addr  per-entry stored word addresses
//   entry_valid per-entry valid bits
//   hit_vec     one-hot match vector (all zero on a miss)
//   hit_idx     encoded index of the matching entry (zero on a miss)
module store_buffer_match
  import data_memory_pkg::*;
#(
  parameter int DEPTH      = ST_BUF_DEPTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int OFS        = 2,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
  input  logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0]                 hit_vec,
  output logic [IDX_W-1:0]                 hit_idx
);

  // Byte-offset bits are masked out so any byte within a word matches.
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'((1 << OFS) - 1);

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = entry_valid[i] && (((addr ^ entry_addr[i]) & WORD_MASK) == '0);
      // At most one entry holds a given word, so OR-encoding is exact.
      if (hit_vec[i]) hit_idx = hit_idx | IDX_W'(i);
    end
  end

endmodule : store_buffer_match

// File: rtl/merging_store_buffer.sv
// merging_store_buffer: circular FIFO of word-aligned stores that merges a
// new store into an existing entry for the same word, presents the oldest
// entry first-word-fall-through to the memory controller, and forwards
// buffered store data to loads.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   flush_i                         discard every entry
//   push_valid_i/push_ready_o       store request handshake
//   push_address_i/_data_i/_byte_en_i  store contents
//   pop_valid_o/pop_ready_i         head entry handshake
//   pop_address_o/_data_o/_byte_en_o   head entry contents
//   fwd_address_i                   load lookup address
//   fwd_hit_o/_data_o/_byte_en_o    lookup result (from registered state)
//   full_o, empty_o, count_o        registered occupancy status
module merging_store_buffer
  import data_memory_pkg::*;
#(
  parameter int DEPTH      = ST_BUF_DEPTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int BE         = DATA_WIDTH / 8,
  parameter int OFS        = $clog2(BE),
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int CNT_W      = IDX_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [ADDR_WIDTH-1:0] push_address_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [BE-1:0]         push_byte_en_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [ADDR_WIDTH-1:0] pop_address_o,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [BE-1:0]         pop_byte_en_o,
  input  logic [ADDR_WIDTH-1:0] fwd_address_i,
  output logic                  fwd_hit_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic [BE-1:0]         fwd_byte_en_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'((1 << OFS) - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE-1:0]         be;
  } entry_t;

  entry_t                         entries [DEPTH];
  logic [DEPTH-1:0]               valid;
  logic [IDX_W-1:0]               head;
  logic [IDX_W-1:0]               tail;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;

  logic [DEPTH-1:0] push_hit_vec;
  logic [IDX_W-1:0] push_idx;
  logic [DEPTH-1:0] fwd_hit_vec;
  logic [IDX_W-1:0] fwd_idx;
  logic [DEPTH-1:0] pop_mask;
  logic             pop;
  logic             merge;
  logic             push_fire;
  logic             alloc;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = entries[i].addr;
  end

  store_buffer_match #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .OFS(OFS), .IDX_W(IDX_W)
  ) u_push_match (
    .addr(push_address_i), .entry_addr(entry_addr), .entry_valid(valid),
    .hit_vec(push_hit_vec), .hit_idx(push_idx)
  );

  store_buffer_match #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .OFS(OFS), .IDX_W(IDX_W)
  ) u_fwd_match (
    .addr(fwd_address_i), .entry_addr(entry_addr), .entry_valid(valid),
    .hit_vec(fwd_hit_vec), .hit_idx(fwd_idx)
  );

  always_comb begin
    pop          = !empty_o && pop_ready_i;
    pop_mask     = pop ? (DEPTH'(1) << head) : '0;
    // A match on the entry leaving this cycle must not absorb the store,
    // otherwise the merged bytes would be lost with the popped entry.
    merge        = |(push_hit_vec & ~pop_mask);
    push_ready_o = !flush_i && (merge || !full_o);
    push_fire    = push_valid_i && push_ready_o;
    alloc        = push_fire && !merge;
    count_next   = count_o + CNT_W'(alloc) - CNT_W'(pop);
  end

  assign pop_valid_o   = !empty_o;
  assign pop_address_o = entries[head].addr;
  assign pop_data_o    = entries[head].data;
  assign pop_byte_en_o = entries[head].be;

  assign fwd_hit_o     = |fwd_hit_vec;
  assign fwd_data_o    = entries[fwd_idx].data;
  assign fwd_byte_en_o = fwd_hit_o ? entries[fwd_idx].be : '0;

  // Control state: valid bits, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid   <= '0;
      head    <= '0;
      tail    <= '0;
      count_o <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + IDX_W'(1);
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + IDX_W'(1);
      end
      count_o <= count_next;
      empty_o <= (count_next == '0);
      full_o  <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Entry storage: no reset, contents qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (merge && push_valid_i && !flush_i) begin
      for (int b = 0; b < BE; b++) begin
        if (push_byte_en_i[b]) entries[push_idx].data[b*8 +: 8] <= push_data_i[b*8 +: 8];
      end
      entries[push_idx].be <= entries[push_idx].be | push_byte_en_i;
    end else if (alloc) begin
      entries[tail].addr <= push_address_i & WORD_MASK;
      entries[tail].data <= push_data_i;
      entries[tail].be   <= push_byte_en_i;
    end
  end

endmodule : merging_store_buffer

// File: tb/tb_merging_store_buffer.sv
// Directed bench for merging_store_buffer (DEPTH=4, 32-bit address/data).
module tb_merging_store_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_address_i;
  logic [31:0] push_data_i;
  logic [3:0]  push_byte_en_i;
  logic        pop_valid_o;
  logic        pop_ready_i;
  logic [31:0] pop_address_o;
  logic [31:0] pop_data_o;
  logic [3:0]  pop_byte_en_o;
  logic [31:0] fwd_address_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic [3:0]  fwd_byte_en_o;
  logic        full_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  always #5 clk_i = ~clk_i;

  merging_store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_address_i(push_address_i), .push_data_i(push_data_i),
    .push_byte_en_i(push_byte_en_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
    .pop_address_o(pop_address_o), .pop_data_o(pop_data_o),
    .pop_byte_en_o(pop_byte_en_o),
    .fwd_address_i(fwd_address_i), .fwd_hit_o(fwd_hit_o),
    .fwd_data_o(fwd_data_o), .fwd_byte_en_o(fwd_byte_en_o),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic with_pop);
    push_valid_i   = 1'b1;
    push_address_i = a;
    push_data_i    = d;
    push_byte_en_i = be;
    pop_ready_i    = with_pop;
    tick();
    push_valid_i   = 1'b0;
    pop_ready_i    = 1'b0;
  endtask

  task automatic pop_one();
    pop_ready_i = 1'b1;
    tick();
    pop_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
    push_address_i = '0; push_data_i = '0; push_byte_en_i = '0; fwd_address_i = '0;
    tick(); tick();
    rst_i = 1'b0;

    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid_o), 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit_o), 32'd0);
    chk("rst_push_ready", 32'(push_ready_o), 32'd1);

    // Single allocation shows up at the head next cycle.
    push(32'h100, 32'hAABBCCDD, 4'hF, 1'b0);
    chk("alloc_count", 32'(count_o), 32'd1);
    chk("alloc_pop_valid", 32'(pop_valid_o), 32'd1);
    chk("alloc_pop_data", pop_data_o, 32'hAABBCCDD);
    chk("alloc_pop_addr", pop_address_o, 32'h100);
    pop_one();
    chk("drain_empty", 32'(empty_o), 32'd1);

    // Two partial stores to one word merge into a single entry.
    push(32'h200, 32'h11223344, 4'h3, 1'b0);
    push(32'h202, 32'h55660000, 4'hC, 1'b0);
    chk("merge_count", 32'(count_o), 32'd1);
    chk("merge_data", pop_data_o, 32'h55663344);
    chk("merge_be", 32'(pop_byte_en_o), 32'hF);
    chk("merge_addr", pop_address_o, 32'h200);
    pop_one();

    // Forwarding, including a same-cycle push not yet visible.
    push(32'h300, 32'hDEADBEEF, 4'hF, 1'b0);
    fwd_address_i = 32'h301; #1;
    chk("fwd_hit", 32'(fwd_hit_o), 32'd1);
    chk("fwd_data", fwd_data_o, 32'hDEADBEEF);
    chk("fwd_be", 32'(fwd_byte_en_o), 32'hF);
    fwd_address_i = 32'h304;
    push_valid_i = 1'b1; push_address_i = 32'h304; push_data_i = 32'h0BADF00D;
    push_byte_en_i = 4'hF; #1;
    chk("fwd_miss_hit", 32'(fwd_hit_o), 32'd0);
    chk("fwd_miss_be", 32'(fwd_byte_en_o), 32'd0);
    tick(); push_valid_i = 1'b0;
    chk("fwd_after_push", fwd_data_o, 32'h0BADF00D);
    push(32'h308, 32'h12345678, 4'hF, 1'b0);
    chk("pre_flush_count", 32'(count_o), 32'd3);

    // Flush wins over a simultaneous push and pop.
    flush_i = 1'b1; push_valid_i = 1'b1; push_address_i = 32'h400;
    push_data_i = 32'h44444444; pop_ready_i = 1'b1; #1;
    chk("flush_push_ready", 32'(push_ready_o), 32'd0);
    tick();
    flush_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
    fwd_address_i = 32'h400; #1;
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_empty", 32'(empty_o), 32'd1);
    chk("flush_no_store", 32'(fwd_hit_o), 32'd0);

    // Fill to capacity.
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'h10 + 32'(i), 4'hF, 1'b0);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd4);
    push_valid_i = 1'b1; push_address_i = 32'h10; push_data_i = 32'h0; push_byte_en_i = 4'hF; #1;
    chk("full_miss_ready", 32'(push_ready_o), 32'd0);
    push_address_i = 32'h8; push_data_i = 32'h000000AA; push_byte_en_i = 4'h1; #1;
    chk("full_merge_ready", 32'(push_ready_o), 32'd1);
    tick(); push_valid_i = 1'b0;
    chk("full_merge_count", 32'(count_o), 32'd4);

    // Full, non-matching push with a pop: push still refused.
    push_valid_i = 1'b1; push_address_i = 32'h10; push_data_i = 32'h0; push_byte_en_i = 4'hF;
    pop_ready_i = 1'b1; #1;
    chk("full_pop_ready", 32'(push_ready_o), 32'd0);
    tick(); push_valid_i = 1'b0; pop_ready_i = 1'b0;
    chk("full_pop_count", 32'(count_o), 32'd3);
    chk("full_pop_head", pop_address_o, 32'h4);
    fwd_address_i = 32'h8; #1;
    chk("merged_fwd_data", fwd_data_o, 32'h000000AA);
    fwd_address_i = 32'h10; #1;
    chk("refused_not_stored", 32'(fwd_hit_o), 32'd0);

    // Push matching the head being popped allocates a fresh entry.
    push(32'h4, 32'h00000055, 4'h1, 1'b1);
    chk("head_hit_count", 32'(count_o), 32'd3);
    chk("head_hit_head", pop_address_o, 32'h8);
    fwd_address_i = 32'h4; #1;
    chk("head_hit_fwd_be", 32'(fwd_byte_en_o), 32'h1);
    chk("head_hit_fwd_data", fwd_data_o, 32'h00000055);

    // Merge into a non-head entry while popping decrements the count.
    push(32'hC, 32'h0000BB00, 4'h2, 1'b1);
    chk("merge_pop_count", 32'(count_o), 32'd2);
    chk("merge_pop_addr", pop_address_o, 32'hC);
    chk("merge_pop_data", pop_data_o, 32'h0000BB13);

    // Five push/pop pairs wrap both pointers; order must hold.
    q_addr = '{32'hC, 32'h4};
    q_data = '{32'h0000BB13, 32'h00000055};
    for (int k = 0; k < 5; k++) begin
      chk("pair_head_addr", pop_address_o, q_addr[0]);
      chk("pair_head_data", pop_data_o, q_data[0]);
      push(32'h500 + 32'(k * 4), 32'hC0DE0000 + 32'(k), 4'hF, 1'b1);
      void'(q_addr.pop_front()); void'(q_data.pop_front());
      q_addr.push_back(32'h500 + 32'(k * 4));
      q_data.push_back(32'hC0DE0000 + 32'(k));
      chk("pair_count", 32'(count_o), 32'd2);
    end
    for (int k = 0; k < 2; k++) begin
      chk("drain_addr", pop_address_o, q_addr[k]);
      chk("drain_data", pop_data_o, q_data[k]);
      pop_one();
    end
    chk("final_empty", 32'(empty_o), 32'd1);
    chk("final_pop_valid", 32'(pop_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_merging_store_buffer
